// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encodings and widths.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned HZ_STATE_WIDTH = 2;

  localparam logic [HZ_STATE_WIDTH-1:0] HZ_RUN      = 2'd0;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_MDU_WAIT = 2'd1;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_FLUSH    = 2'd2;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-sequencer bundle between the pipeline (master) and pipe_hazard_ctrl (slave).
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t D_rs1_i;
  reg_idx_t D_rs2_i;
  logic     D_use_rs1_i;
  logic     D_use_rs2_i;
  reg_idx_t E_dstE_i;
  logic     E_need_dstE_i;
  logic     E_is_load_i;
  logic     E_mispredict_i;
  logic     E_mdu_start_i;
  logic     mdu_done_i;
  logic     M_mem_req_i;
  logic     M_mem_ready_i;

  logic F_stall_o;
  logic D_stall_o;
  logic E_stall_o;
  logic F_bubble_o;
  logic D_bubble_o;
  logic M_bubble_o;
  logic redirect_o;
  logic [HZ_STATE_WIDTH-1:0] state_o;
  logic mdu_err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc_o;
  logic [31:0] flush_cyc_o;
`endif

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    output E_dstE_i, E_need_dstE_i, E_is_load_i, E_mispredict_i, E_mdu_start_i,
    output mdu_done_i, M_mem_req_i, M_mem_ready_i,
    input  F_stall_o, D_stall_o, E_stall_o, F_bubble_o, D_bubble_o, M_bubble_o,
    input  redirect_o, state_o, mdu_err_o
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cyc_o, flush_cyc_o
`endif
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    input  E_dstE_i, E_need_dstE_i, E_is_load_i, E_mispredict_i, E_mdu_start_i,
    input  mdu_done_i, M_mem_req_i, M_mem_ready_i,
    output F_stall_o, D_stall_o, E_stall_o, F_bubble_o, D_bubble_o, M_bubble_o,
    output redirect_o, state_o, mdu_err_o
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cyc_o, flush_cyc_o
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_loaduse_cmp.sv
// Combinational load-use detector: flags a D-stage read of a register an E-stage load writes.
module hz_loaduse_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  logic     use_rs1,
  input  logic     use_rs2,
  input  reg_idx_t dst,
  input  logic     need_dst,
  input  logic     is_load,
  output logic     hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1 && (rs1 == dst);
  assign rs2_hit = use_rs2 && (rs2 == dst);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard  = is_load && need_dst && (dst != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble sequencer for the 5-stage pipeline (RUN / MDU_WAIT / FLUSH).
// Optional HAZARD_PERF_CNT_EN adds saturating stall and flush cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MDU_TIMEOUT  = 64
) (
  input logic clk_i,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  logic [HZ_STATE_WIDTH-1:0] state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       err_q, err_d;

  logic f_stall, d_stall, e_stall;
  logic f_bubble, d_bubble, m_bubble, redirect;
  logic mem_wait, load_use;

  assign mem_wait = hz.M_mem_req_i && !hz.M_mem_ready_i;

  hz_loaduse_cmp u_loaduse (
    .rs1      (hz.D_rs1_i),
    .rs2      (hz.D_rs2_i),
    .use_rs1  (hz.D_use_rs1_i),
    .use_rs2  (hz.D_use_rs2_i),
    .dst      (hz.E_dstE_i),
    .need_dst (hz.E_need_dstE_i),
    .is_load  (hz.E_is_load_i),
    .hazard   (load_use)
  );

  always_comb begin
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    e_stall     = 1'b0;
    f_bubble    = 1'b0;
    d_bubble    = 1'b0;
    m_bubble    = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    err_d       = err_q;

    if (!rst_n) begin
      // Outputs follow reset combinationally so the pipeline sees nops immediately
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (mem_wait) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_bubble = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (hz.E_mispredict_i) begin
            redirect = 1'b1;
            f_bubble = 1'b1;
            d_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = HZ_FLUSH;
              flush_cnt_d = 4'(FLUSH_CYCLES - 1);
            end
          end else if (hz.E_mdu_start_i && !hz.mdu_done_i) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_bubble = 1'b1;
            state_d  = HZ_MDU_WAIT;
            wd_cnt_d = 8'd1;
          end else if (load_use) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
          end
        end
        HZ_MDU_WAIT: begin
          if (hz.mdu_done_i) begin
            state_d  = HZ_RUN;
            wd_cnt_d = '0;
          end else if (wd_cnt_q == 8'(MDU_TIMEOUT)) begin
            err_d    = 1'b1;
            state_d  = HZ_RUN;
            wd_cnt_d = '0;
          end else begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_bubble = 1'b1;
            wd_cnt_d = wd_cnt_q + 8'd1;
          end
        end
        HZ_FLUSH: begin
          d_bubble = 1'b1;
          if (hz.E_mispredict_i) begin
            redirect    = 1'b1;
            f_bubble    = 1'b1;
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
          end else if (flush_cnt_q == 4'd1) begin
            state_d     = HZ_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      flush_cnt_q <= '0;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
    end
  end

  assign hz.F_stall_o  = f_stall;
  assign hz.D_stall_o  = d_stall;
  assign hz.E_stall_o  = e_stall;
  assign hz.F_bubble_o = f_bubble;
  assign hz.D_bubble_o = d_bubble;
  assign hz.M_bubble_o = m_bubble;
  assign hz.redirect_o = redirect;
  assign hz.state_o    = state_q;
  assign hz.mdu_err_o  = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] flush_cyc_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      if (f_stall && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (d_bubble && (flush_cyc_q != '1)) flush_cyc_q <= flush_cyc_q + 32'd1;
    end
  end

  assign hz.stall_cyc_o = stall_cyc_q;
  assign hz.flush_cyc_o = flush_cyc_q;
`endif

endmodule
